// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and
// default framing constants used as parameter defaults by the receiver.
package uart_pkg;

    // Receiver FSM states; the encoding is exported on state_o for debug
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_rx_state_e;

    // Default framing: 16x oversampling, 8 data bits, 1 stop bit
    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_STOP_BITS  = 1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line. Both stages reset
// to 1 so an idle (high) line is seen while the receiver comes out of reset.
module uart_rx_sync (
    input  logic baud_clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the raw line into the baud_clk domain
    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller. Oversamples the synchronised rx line, finds the
// start-bit centre, samples DATA_BITS data bits LSB first, checks STOP_BITS
// stop bits and hands completed bytes to the host through a valid/ready
// holding register. Framing and overrun errors are one-cycle pulses.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
    parameter int unsigned DATA_BITS  = UART_DATA_BITS,
    parameter int unsigned STOP_BITS  = UART_STOP_BITS
) (
    input  logic                 baud_clk,
    input  logic                 rst_n,
    input  logic                 rx_in,
    input  logic                 enable,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy,
    output logic [2:0]           state_o
);

    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    // Sample points inside a bit period: centre of the start bit, and the
    // last tick of each data/stop bit (which lands on the bit centre because
    // the count restarts at the start-bit centre).
    localparam logic [SW-1:0] SMP_MID   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SMP_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    uart_rx_state_e       r_state;
    logic [SW-1:0]        r_sample_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shreg;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_overrun_err;

    logic                 w_rx_s;
    logic                 w_sample_last;
    logic                 w_frame_done;

    uart_rx_sync u_sync (
        .baud_clk (baud_clk),
        .rst_n    (rst_n),
        .i_async  (rx_in),
        .o_sync   (w_rx_s)
    );

    assign w_sample_last = (r_sample_cnt == SMP_LAST);

    // A frame completes on the last stop-bit sample when it reads high.
    // enable=0 takes priority and aborts the frame instead.
    assign w_frame_done = enable
                       && (r_state == STOP)
                       && w_sample_last
                       && w_rx_s
                       && (r_bit_cnt == STOP_LAST);

    // Receive FSM: bit timing counters, shift register and framing check
    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_sample_cnt <= '0;
            r_bit_cnt    <= '0;
            r_shreg      <= '0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (!enable && (r_state != IDLE)) begin
                r_state      <= IDLE;
                r_sample_cnt <= '0;
                r_bit_cnt    <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (enable && !w_rx_s) begin
                            r_state      <= START;
                            r_sample_cnt <= '0;
                        end
                    end

                    START: begin
                        if (r_sample_cnt == SMP_MID) begin
                            r_sample_cnt <= '0;
                            r_bit_cnt    <= '0;
                            // Line back high at the start-bit centre: noise
                            r_state      <= w_rx_s ? IDLE : DATA;
                        end else begin
                            r_sample_cnt <= r_sample_cnt + 1'b1;
                        end
                    end

                    DATA: begin
                        if (w_sample_last) begin
                            r_shreg      <= {w_rx_s, r_shreg[DATA_BITS-1:1]};
                            r_sample_cnt <= '0;
                            if (r_bit_cnt == BIT_LAST) begin
                                r_state   <= STOP;
                                r_bit_cnt <= '0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end else begin
                            r_sample_cnt <= r_sample_cnt + 1'b1;
                        end
                    end

                    STOP: begin
                        if (w_sample_last) begin
                            r_sample_cnt <= '0;
                            if (!w_rx_s) begin
                                r_frame_err <= 1'b1;
                                r_bit_cnt   <= '0;
                                r_state     <= WAIT_HIGH;
                            end else if (r_bit_cnt == STOP_LAST) begin
                                r_bit_cnt <= '0;
                                r_state   <= IDLE;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end else begin
                            r_sample_cnt <= r_sample_cnt + 1'b1;
                        end
                    end

                    WAIT_HIGH: begin
                        // Hold off during a break so a long low line cannot
                        // restart reception or repeat the framing error
                        if (w_rx_s) begin
                            r_state <= IDLE;
                        end
                    end

                    default: begin
                        r_state      <= IDLE;
                        r_sample_cnt <= '0;
                        r_bit_cnt    <= '0;
                    end
                endcase
            end
        end
    end

    // Host holding register: load on completion, drop and flag overrun if
    // still full, clear on a transfer that has no completion alongside it
    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_overrun_err <= 1'b0;
            if (w_frame_done) begin
                if (!r_rx_valid || rx_ready) begin
                    r_rx_data  <= r_shreg;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_overrun_err <= 1'b1;
                end
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign frame_err   = r_frame_err;
    assign overrun_err = r_overrun_err;
    assign busy        = (r_state != IDLE);
    assign state_o     = r_state;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl. Frames are driven as serial
// waveforms one bit period (16 ticks) at a time; expectations come from the
// frame contents, the documented latency and the handshake rules.
module tb_uart_rx_ctrl;
    import uart_pkg::*;

    localparam int OS = 16;
    localparam int DB = 8;

    logic          baud_clk = 1'b0;
    logic          rst_n    = 1'b0;
    logic          rx_in    = 1'b1;
    logic          enable   = 1'b0;
    logic          rx_ready = 1'b0;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          overrun_err;
    logic          busy;
    logic [2:0]    state_o;

    int checks = 0;
    int fails  = 0;

    int cyc = 0;
    int fe_cnt = 0;
    int oe_cnt = 0;
    int rise_cyc = -1;
    logic prev_valid = 1'b0;
    int frame_first_edge = 0;
    logic [DB-1:0] acc_q[$];
    logic [DB-1:0] exp_q[$];

    uart_rx_ctrl #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB),
        .STOP_BITS  (1)
    ) dut (
        .baud_clk    (baud_clk),
        .rst_n       (rst_n),
        .rx_in       (rx_in),
        .enable      (enable),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .busy        (busy),
        .state_o     (state_o)
    );

    always #5 baud_clk = ~baud_clk;

    // Edge counter and transfer log (pre-edge values seen at the active edge)
    always @(posedge baud_clk) begin
        cyc <= cyc + 1;
        if (rst_n && rx_valid && rx_ready) acc_q.push_back(rx_data);
    end

    // Pulse counters and rx_valid rise time
    always @(negedge baud_clk) begin
        if (rst_n) begin
            if (frame_err)   fe_cnt++;
            if (overrun_err) oe_cnt++;
            if (rx_valid && !prev_valid) rise_cyc = cyc;
        end
        prev_valid = rx_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (OS) @(negedge baud_clk);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop_v);
        frame_first_edge = cyc + 1;
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
        drive_bit(stop_v);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; enable = 1'b0; rx_in = 1'b1; rx_ready = 1'b0;
        repeat (3) @(negedge baud_clk);
        checks++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %0h expected 0", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %0b expected 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %0b expected 0", frame_err); end
        checks++; if (overrun_err !== 1'b0) begin fails++; $display("FAIL reset_overrun_err: got %0b expected 0", overrun_err); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (state_o !== IDLE) begin fails++; $display("FAIL reset_state: got %0d expected 0", state_o); end
        rst_n = 1'b1;
        enable = 1'b1;
        repeat (4) @(negedge baud_clk);
    endtask

    task automatic test_frame_a5;
        int fe0, oe0, n0, lat;
        rx_ready = 1'b1;
        fe0 = fe_cnt; oe0 = oe_cnt; n0 = acc_q.size(); rise_cyc = -1;
        send_frame(8'hA5, 1'b1);
        repeat (4) @(negedge baud_clk);
        lat = rise_cyc - frame_first_edge + 1;
        checks++; if (rise_cyc < 0 || lat < 154 || lat > 156) begin fails++; $display("FAIL a5_latency: got edge %0d expected 155", lat); end
        checks++; if (rx_data !== 8'hA5) begin fails++; $display("FAIL a5_rx_data: got %0h expected a5", rx_data); end
        checks++;
        if (acc_q.size() != n0 + 1) begin fails++; $display("FAIL a5_transfers: got %0d expected %0d", acc_q.size() - n0, 1); end
        else if (acc_q[n0] !== 8'hA5) begin fails++; $display("FAIL a5_transfer_data: got %0h expected a5", acc_q[n0]); end
        checks++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL a5_valid_cleared: got %0b expected 0", rx_valid); end
        checks++; if (fe_cnt - fe0 != 0 || oe_cnt - oe0 != 0) begin fails++; $display("FAIL a5_errors: got fe=%0d oe=%0d expected 0 0", fe_cnt - fe0, oe_cnt - oe0); end
    endtask

    task automatic test_glitch;
        logic saw_start;
        int fe0;
        saw_start = 1'b0;
        fe0 = fe_cnt;
        rx_in = 1'b0;
        repeat (4) begin @(negedge baud_clk); if (state_o == START) saw_start = 1'b1; end
        rx_in = 1'b1;
        repeat (8) begin @(negedge baud_clk); if (state_o == START) saw_start = 1'b1; end
        checks++; if (saw_start !== 1'b1) begin fails++; $display("FAIL glitch_start_seen: got %0b expected 1", saw_start); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_busy: got %0b expected 0", busy); end
        checks++; if (rx_valid !== 1'b0 || fe_cnt != fe0) begin fails++; $display("FAIL glitch_outputs: got valid=%0b fe=%0d expected 0 0", rx_valid, fe_cnt - fe0); end
    endtask

    task automatic test_frame_err;
        int fe0, n0;
        rx_ready = 1'b1;
        fe0 = fe_cnt; n0 = acc_q.size();
        send_frame(8'h3C, 1'b0);
        repeat (40) @(negedge baud_clk);
        checks++; if (fe_cnt - fe0 != 1) begin fails++; $display("FAIL ferr_pulses: got %0d expected 1", fe_cnt - fe0); end
        checks++; if (state_o !== WAIT_HIGH) begin fails++; $display("FAIL ferr_wait_high: got %0d expected 4", state_o); end
        rx_in = 1'b1;
        repeat (4) @(negedge baud_clk);
        checks++; if (state_o !== IDLE) begin fails++; $display("FAIL ferr_back_idle: got %0d expected 0", state_o); end
        checks++; if (fe_cnt - fe0 != 1) begin fails++; $display("FAIL ferr_no_repeat: got %0d expected 1", fe_cnt - fe0); end
        checks++; if (rx_valid !== 1'b0 || acc_q.size() != n0) begin fails++; $display("FAIL ferr_no_data: got valid=%0b transfers=%0d expected 0 0", rx_valid, acc_q.size() - n0); end
    endtask

    task automatic test_overrun;
        int oe0, n0;
        rx_ready = 1'b0;
        oe0 = oe_cnt; n0 = acc_q.size();
        send_frame(8'h11, 1'b1);
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin fails++; $display("FAIL ovr_first: got valid=%0b data=%0h expected 1 11", rx_valid, rx_data); end
        send_frame(8'h22, 1'b1);
        repeat (2) @(negedge baud_clk);
        checks++; if (oe_cnt - oe0 != 1) begin fails++; $display("FAIL ovr_pulses: got %0d expected 1", oe_cnt - oe0); end
        checks++; if (rx_data !== 8'h11 || rx_valid !== 1'b1) begin fails++; $display("FAIL ovr_held: got valid=%0b data=%0h expected 1 11", rx_valid, rx_data); end
        rx_ready = 1'b1;
        @(negedge baud_clk);
        rx_ready = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL ovr_drain: got %0b expected 0", rx_valid); end
        checks++;
        if (acc_q.size() != n0 + 1) begin fails++; $display("FAIL ovr_transfers: got %0d expected 1", acc_q.size() - n0); end
        else if (acc_q[n0] !== 8'h11) begin fails++; $display("FAIL ovr_transfer_data: got %0h expected 11", acc_q[n0]); end
    endtask

    task automatic test_ready_on_completion;
        int oe0, n0;
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        oe0 = oe_cnt; n0 = acc_q.size();
        fork
            send_frame(8'h22, 1'b1);
            begin
                // completion edge is the 155th edge from the first low sample
                repeat (154) @(negedge baud_clk);
                rx_ready = 1'b1;
                @(negedge baud_clk);
                rx_ready = 1'b0;
            end
        join
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h22) begin fails++; $display("FAIL roc_data: got valid=%0b data=%0h expected 1 22", rx_valid, rx_data); end
        checks++; if (oe_cnt - oe0 != 0) begin fails++; $display("FAIL roc_overrun: got %0d expected 0", oe_cnt - oe0); end
        checks++;
        if (acc_q.size() != n0 + 1) begin fails++; $display("FAIL roc_transfers: got %0d expected 1", acc_q.size() - n0); end
        else if (acc_q[n0] !== 8'h11) begin fails++; $display("FAIL roc_transfer_data: got %0h expected 11", acc_q[n0]); end
    endtask

    task automatic test_reset_mid_frame;
        logic [DB-1:0] d;
        int fe0, oe0, n0;
        d = 8'hE7;
        rx_ready = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx_in = d[4];
        repeat (8) @(negedge baud_clk);
        checks++; if (state_o !== DATA || busy !== 1'b1) begin fails++; $display("FAIL rst_mid_in_data: got state=%0d busy=%0b expected 2 1", state_o, busy); end
        rst_n = 1'b0;
        #2;
        checks++; if (rx_data !== 8'h00 || rx_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_holding: got valid=%0b data=%0h expected 0 0", rx_valid, rx_data); end
        checks++; if (frame_err !== 1'b0 || overrun_err !== 1'b0) begin fails++; $display("FAIL rst_mid_flags: got fe=%0b oe=%0b expected 0 0", frame_err, overrun_err); end
        checks++; if (busy !== 1'b0 || state_o !== IDLE) begin fails++; $display("FAIL rst_mid_state: got busy=%0b state=%0d expected 0 0", busy, state_o); end
        @(negedge baud_clk);
        rx_in = 1'b1;
        @(negedge baud_clk);
        rst_n = 1'b1;
        repeat (20) @(negedge baud_clk);
        rx_ready = 1'b1;
        fe0 = fe_cnt; oe0 = oe_cnt; n0 = acc_q.size();
        send_frame(8'h5A, 1'b1);
        repeat (3) @(negedge baud_clk);
        checks++;
        if (acc_q.size() != n0 + 1) begin fails++; $display("FAIL rst_mid_next_count: got %0d expected 1", acc_q.size() - n0); end
        else if (acc_q[n0] !== 8'h5A) begin fails++; $display("FAIL rst_mid_next_data: got %0h expected 5a", acc_q[n0]); end
        checks++; if (fe_cnt != fe0 || oe_cnt != oe0) begin fails++; $display("FAIL rst_mid_next_errors: got fe=%0d oe=%0d expected 0 0", fe_cnt - fe0, oe_cnt - oe0); end
    endtask

    task automatic test_enable_abort;
        int fe0, oe0;
        rx_ready = 1'b0;
        send_frame(8'h96, 1'b1);
        fe0 = fe_cnt; oe0 = oe_cnt;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        checks++; if (state_o !== DATA) begin fails++; $display("FAIL en_in_data: got %0d expected 2", state_o); end
        enable = 1'b0;
        @(negedge baud_clk);
        checks++; if (busy !== 1'b0 || state_o !== IDLE) begin fails++; $display("FAIL en_abort: got busy=%0b state=%0d expected 0 0", busy, state_o); end
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h96) begin fails++; $display("FAIL en_holding: got valid=%0b data=%0h expected 1 96", rx_valid, rx_data); end
        repeat (8) @(negedge baud_clk);
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL en_disabled_idle: got %0b expected 0", busy); end
        rx_in = 1'b1;
        repeat (4) @(negedge baud_clk);
        enable = 1'b1;
        repeat (20) @(negedge baud_clk);
        checks++; if (fe_cnt != fe0 || oe_cnt != oe0) begin fails++; $display("FAIL en_no_flags: got fe=%0d oe=%0d expected 0 0", fe_cnt - fe0, oe_cnt - oe0); end
        rx_ready = 1'b1;
        @(negedge baud_clk);
        rx_ready = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL en_drain: got %0b expected 0", rx_valid); end
    endtask

    task automatic test_random;
        int fe0, oe0, n0, gap;
        logic [DB-1:0] d;
        rx_ready = 1'b1;
        fe0 = fe_cnt; oe0 = oe_cnt; n0 = acc_q.size();
        exp_q.delete();
        for (int k = 0; k < 10; k++) begin
            d = 8'($urandom_range(0, 255));
            exp_q.push_back(d);
            send_frame(d, 1'b1);
            gap = int'($urandom_range(0, 12));
            repeat (gap) @(negedge baud_clk);
        end
        repeat (4) @(negedge baud_clk);
        checks++; if (acc_q.size() - n0 != exp_q.size()) begin fails++; $display("FAIL rand_count: got %0d expected %0d", acc_q.size() - n0, exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            if (n0 + k < acc_q.size()) begin
                checks++;
                if (acc_q[n0 + k] !== exp_q[k]) begin fails++; $display("FAIL rand_data[%0d]: got %0h expected %0h", k, acc_q[n0 + k], exp_q[k]); end
            end
        end
        checks++; if (fe_cnt != fe0 || oe_cnt != oe0) begin fails++; $display("FAIL rand_errors: got fe=%0d oe=%0d expected 0 0", fe_cnt - fe0, oe_cnt - oe0); end
    endtask

    initial begin
        test_reset;
        test_frame_a5;
        test_glitch;
        test_frame_err;
        test_overrun;
        test_ready_on_completion;
        test_reset_mid_frame;
        test_enable_abort;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
